// File: rtl/pipe_pkg.sv
// Shared helpers for the stall-controlled pipeline sink: width derivations
// for FIFO pointers and occupancy counters.
package pipe_pkg;

   // Ceiling log2, minimum result 0 (clog2(1) == 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Pointer width for a FIFO of the given depth; pointers wrap naturally.
   function automatic int ptr_w(input int depth);
      return clog2(depth);
   endfunction

   // Level counter width: one bit wider than the pointer so it can hold depth.
   function automatic int lvl_w(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sink_mem.sv
// Two-port register array: synchronous write, asynchronous read, no reset.
module sink_mem #(
   parameter int p_width  = 8,
   parameter int p_depth  = 8,
   parameter int p_addr_w = 3
) (
   input  logic                i_clk,
   input  logic                we,
   input  logic [p_addr_w-1:0] waddr,
   input  logic [p_width-1:0]  wdata,
   input  logic [p_addr_w-1:0] raddr,
   output logic [p_width-1:0]  rdata
);

   logic [p_width-1:0] mem [p_depth];

   // Store the incoming word at the write address when enabled.
   always_ff @(posedge i_clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stall_sink_fifo.sv
// Consumer end of the stall-controlled pipeline. Absorbs the pipeline stream
// into a small first-word-fall-through FIFO, raises a registered stall early
// enough that in-flight words (p_skid of them) still fit, and re-presents the
// data on a valid/ready handshake.
//
// Handshake: a word moves downstream in every cycle where out_valid and
// out_ready are both high; out stays stable while out_valid=1 and
// out_ready=0. Upstream words are taken whenever in_valid=1 and there is
// room (including room freed by a same-cycle pop), regardless of o_stall.
module stall_sink_fifo
   import pipe_pkg::*;
#(
   parameter int p_width = 8,
   parameter int p_depth = 8,
   parameter int p_skid  = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [p_width-1:0]          in,
   input  logic                        in_valid,
   output logic                        o_stall,
   output logic [p_width-1:0]          out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [lvl_w(p_depth)-1:0]   o_level,
   output logic                        o_overflow
);

   localparam int PW = ptr_w(p_depth);
   localparam int LW = lvl_w(p_depth);
   localparam logic [LW-1:0] FULL_LVL = LW'(p_depth);
   localparam logic [LW-1:0] STALL_LVL = LW'(p_depth - p_skid);

   if ((p_depth < 4) || ((p_depth & (p_depth - 1)) != 0)) begin : g_bad_depth
      $error("stall_sink_fifo: p_depth must be a power of two >= 4");
   end
   if ((p_skid < 1) || (p_skid >= p_depth)) begin : g_bad_skid
      $error("stall_sink_fifo: p_skid must satisfy 1 <= p_skid < p_depth");
   end

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [LW-1:0] level;
   logic [LW-1:0] level_next;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   assign full      = (level == FULL_LVL);
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push      = in_valid & (~full | pop);
   assign drop      = in_valid & full & ~pop;

   // Post-update occupancy; also feeds the stall register so stall tracks
   // the level that will exist after this edge.
   always_comb begin
      level_next = level;
      case ({push, pop})
         2'b10:   level_next = level + 1'b1;
         2'b01:   level_next = level - 1'b1;
         default: level_next = level;
      endcase
   end

   // Pointers, level, stall and sticky overflow.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         o_stall    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level   <= level_next;
         o_stall <= (level_next >= STALL_LVL);
         if (drop) o_overflow <= 1'b1;
      end
   end

   sink_mem #(
      .p_width  (p_width),
      .p_depth  (p_depth),
      .p_addr_w (PW)
   ) u_mem (
      .i_clk (i_clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in),
      .raddr (rd_ptr),
      .rdata (out)
   );

   assign o_level = level;

endmodule

// File: doc/stall_sink_fifo.md
Name: stall_sink_fifo

Overview:
- Consumer end of the stall-controlled pipeline protocol (in/in_valid forward, i_stall backward) used by shiftbuffer.
- Absorbs the pipeline output stream into a small FIFO.
- Generates the registered stall signal that freezes the upstream pipeline before the FIFO can overflow.
- Re-presents data to the downstream consumer on a valid/ready handshake.

Parameters:
p_width, 8, data word width in bits
p_depth, 8, FIFO entries; power of two, >= 4
p_skid, 2, entries reserved for words still arriving after stall rises; 1 <= p_skid < p_depth

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous, active-high reset
in  input  p_width  data word from upstream pipeline
in_valid  input  1  in carries a valid word this cycle
o_stall  output  1  registered stall to upstream pipeline (drives its i_stall)
out  output  p_width  head-of-FIFO word
out_valid  output  1  out holds a valid word
out_ready  input  1  downstream accepts out this cycle
o_level  output  clog2(p_depth)+1  current occupancy, 0..p_depth
o_overflow  output  1  sticky: a word was dropped

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - Read/write pointers and level go to 0; o_stall=0, out_valid=0, o_overflow=0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all stored words; the next cycle shows out_valid=0.
  - in_valid during a reset cycle is ignored.
- Pop:
  - pop = out_valid & out_ready.
  - Advances the read pointer (wraps at p_depth) and decrements level.
- Push:
  - push = in_valid & (level < p_depth | pop).
  - Writes in at the write pointer (wraps at p_depth) and increments level.
- Simultaneous push and pop: level unchanged. When full, the pop frees the slot for the push in the same cycle.
- Overflow: in_valid & level==p_depth & !pop.
  - The word is dropped and o_overflow is set.
  - o_overflow stays set until reset. FIFO state is unchanged.
- Read timing: first-word-fall-through.
  - out = mem[rd_ptr]; out_valid = (level != 0).
  - A word pushed at edge N is visible on out in cycle N+1.
  - There is no same-cycle bypass when the FIFO is empty.
- out is stable while out_valid=1 and out_ready=0.
- o_stall:
  - Register updated every edge: o_stall <= (level_next >= p_depth - p_skid), where level_next is the post-update level.
  - Upstream sees stall one cycle after the level crosses the threshold.
  - p_skid covers words already in flight when stall rises.
  - Deasserts at the edge where level_next falls below the threshold.
  - There is no hysteresis.
- in_valid while o_stall=1 is legal and is accepted if space exists.
- Width rules: pointers are clog2(p_depth) bits and wrap naturally; the level counter is one bit wider.
- Elaboration: illegal parameters (non-power-of-two depth, p_skid out of range) stop elaboration with an error.

Decomposition:
- Shared package pipe_pkg: clog2 function, pointer-width and level-width constants derived from p_depth.
- One sub-module, sink_mem:
  - 2-port register array, p_depth x p_width.
  - Synchronous write (we, waddr, wdata); asynchronous read (raddr -> rdata).
  - No reset.
- Control (pointers, level, stall, overflow) stays in stall_sink_fifo.

Test Plan (p_width=8, p_depth=8, p_skid=2, stall threshold 6):
1. Reset then idle: hold in_valid=0 for 5 cycles -> out_valid=0, o_stall=0, o_level=0, o_overflow=0 every cycle.
2. Basic flow: out_ready=1, push 1,2,3 on consecutive cycles -> out shows 1,2,3 in cycles N+1..N+3; o_level never exceeds 1; o_stall stays 0.
3. Stall threshold: out_ready=0, push 1..6 -> o_level=6 and o_stall=1 one edge after the 6th push; push 7,8 during stall -> o_level=8, no overflow.
4. Overflow: from full with out_ready=0, push 9 -> o_overflow=1 (stays set); o_level=8; drain yields 1..8 only.
5. Full with simultaneous push/pop: at level 8, out_ready=1 and push 9 in the same cycle -> out=1 popped, 9 stored, o_level=8, o_overflow=0; o_stall deasserts only once the level drops to 5.
6. Reset mid-operation: level 4, assert i_rst for one cycle with in_valid=1 -> next cycle o_level=0, out_valid=0, o_stall=0, o_overflow=0; next push of 0x5A appears on out one cycle later.
